// File: rtl/pwm_multi_gen.sv
// Multi-channel PWM generator. A shared prescaled timebase drives NUM_CH
// compare lanes. Edge- and centre-aligned counting, shadowed mode/TOP/duty
// applied at period boundaries, and a simple write port for configuration.

// One compare channel: duty shadow/active pair and the registered output.
module pwm_lane #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             sh_we,
   input  logic             load,
   input  logic             run,
   input  logic             en,
   input  logic             pol,
   input  logic [CNT_W-1:0] wdata,
   input  logic [CNT_W-1:0] cnt,
   output logic             pwm
);
   logic [CNT_W-1:0] duty_sh, duty_act, duty_nxt;

   // a write in the boundary cycle must land in the active copy too
   assign duty_nxt = sh_we ? wdata : duty_sh;

   // duty shadow/active registers and output compare
   always_ff @(posedge clk) begin
      if (rst) begin
         duty_sh  <= '0;
         duty_act <= '0;
         pwm      <= 1'b0;
      end else begin
         duty_sh <= duty_nxt;
         if (load) duty_act <= duty_nxt;
         pwm <= run & en & ((cnt < duty_act) ^ pol);
      end
   end
endmodule

module pwm_multi_gen #(
   parameter int NUM_CH = 8,
   parameter int CNT_W  = 8,
   parameter int ADDR_W = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cfg_we,
   input  logic [ADDR_W-1:0] cfg_addr,
   input  logic [CNT_W-1:0]  cfg_wdata,
   input  logic [NUM_CH-1:0] ch_en,
   input  logic [NUM_CH-1:0] ch_pol,
   output logic [NUM_CH-1:0] pwm_out,
   output logic              period_stb,
   output logic              running
);
   localparam int STAGES = 1;

   typedef struct packed {
      logic              we;
      logic [ADDR_W-1:0] addr;
      logic [CNT_W-1:0]  data;
   } cfg_req_t;

   typedef enum logic {DIR_UP = 1'b0, DIR_DN = 1'b1} dir_t;

   cfg_req_t         req;
   logic             wr_ctrl, wr_pre, wr_top;
   logic             run, run_nxt;
   logic             mode_sh, mode_act, mode_nxt;
   logic [CNT_W-1:0] top_sh, top_act, top_nxt;
   logic [CNT_W-1:0] presc;
   logic [CNT_W-1:0] pre_cnt, pre_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt, cnt_inc;
   dir_t             dir, dir_nxt;
   logic             tick, boundary, load;
   logic [STAGES:0]  vld_pipe;

   assign req     = {cfg_we, cfg_addr, cfg_wdata};
   assign wr_ctrl = req.we && (req.addr == ADDR_W'(0));
   assign wr_pre  = req.we && (req.addr == ADDR_W'(1));
   assign wr_top  = req.we && (req.addr == ADDR_W'(2));

   assign run_nxt  = wr_ctrl ? req.data[0] : run;
   assign mode_nxt = wr_ctrl ? req.data[1] : mode_sh;
   assign top_nxt  = wr_top  ? req.data    : top_sh;

   assign tick    = (pre_cnt == presc);
   assign cnt_inc = cnt + CNT_W'(1);
   // centre boundary is the turn-around at 0; TOP=0 makes every tick one
   assign boundary = run & tick &
                     (mode_act ? ((cnt == '0) && ((dir == DIR_DN) || (top_act == '0)))
                               : (cnt == top_act));
   // stopped: keep active set tracking the shadows so the first count uses them
   assign load = ~run | boundary;

   // next counter/prescaler/direction; a mode change restarts at 0 counting up
   always_comb begin
      pre_nxt = pre_cnt;
      cnt_nxt = cnt;
      dir_nxt = dir;
      if (!run) begin
         pre_nxt = '0;
         cnt_nxt = '0;
         dir_nxt = DIR_UP;
      end else if (tick) begin
         pre_nxt = '0;
         if (boundary) begin
            if ((mode_nxt != mode_act) || !mode_nxt || (top_nxt == '0)) begin
               cnt_nxt = '0;
               dir_nxt = DIR_UP;
            end else begin
               cnt_nxt = CNT_W'(1);
               dir_nxt = (top_nxt == CNT_W'(1)) ? DIR_DN : DIR_UP;
            end
         end else if (!mode_act) begin
            cnt_nxt = cnt_inc;
            dir_nxt = DIR_UP;
         end else if (dir == DIR_UP) begin
            cnt_nxt = cnt_inc;
            dir_nxt = (cnt_inc == top_act) ? DIR_DN : DIR_UP;
         end else begin
            cnt_nxt = cnt - CNT_W'(1);
            dir_nxt = DIR_DN;
         end
      end else begin
         pre_nxt = pre_cnt + CNT_W'(1);
      end
   end

   // config, timebase state and period strobe pipeline
   always_ff @(posedge clk) begin
      if (rst) begin
         run      <= 1'b0;
         mode_sh  <= 1'b0;
         mode_act <= 1'b0;
         top_sh   <= '0;
         top_act  <= '0;
         presc    <= '0;
         pre_cnt  <= '0;
         cnt      <= '0;
         dir      <= DIR_UP;
         vld_pipe <= '0;
      end else begin
         run     <= run_nxt;
         mode_sh <= mode_nxt;
         top_sh  <= top_nxt;
         if (wr_pre) presc <= req.data;
         if (load) begin
            mode_act <= mode_nxt;
            top_act  <= top_nxt;
         end
         pre_cnt <= pre_nxt;
         cnt     <= cnt_nxt;
         dir     <= dir_nxt;
         // extra stage lines the strobe up with the first output of the new period
         vld_pipe <= {vld_pipe[0] & run, boundary};
      end
   end

   assign period_stb = vld_pipe[STAGES];
   assign running    = run;

   for (genvar i = 0; i < NUM_CH; i++) begin : g_lane
      pwm_lane #(.CNT_W(CNT_W)) u_lane (
         .clk   (clk),
         .rst   (rst),
         .sh_we (req.we && (req.addr == ADDR_W'(i + 3))),
         .load  (load),
         .run   (run),
         .en    (ch_en[i]),
         .pol   (ch_pol[i]),
         .wdata (req.data),
         .cnt   (cnt),
         .pwm   (pwm_out[i])
      );
   end
endmodule

// File: tb/tb_pwm_multi_gen.sv
// Bench for pwm_multi_gen: per-cycle comparison against a period-phase
// model, directed waveform measurements with literal expectations, and a
// randomized configuration phase.
module tb_pwm_multi_gen;
   localparam int NUM_CH = 8;
   localparam int CNT_W  = 8;
   localparam int ADDR_W = 5;
   localparam int MASK   = (1 << CNT_W) - 1;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              cfg_we = 1'b0;
   logic [ADDR_W-1:0] cfg_addr = '0;
   logic [CNT_W-1:0]  cfg_wdata = '0;
   logic [NUM_CH-1:0] ch_en = '0;
   logic [NUM_CH-1:0] ch_pol = '0;
   logic [NUM_CH-1:0] pwm_out;
   logic              period_stb;
   logic              running;

   int total = 0;
   int bad   = 0;

   pwm_multi_gen #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .ADDR_W(ADDR_W)) dut (
      .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
      .cfg_wdata(cfg_wdata), .ch_en(ch_en), .ch_pol(ch_pol),
      .pwm_out(pwm_out), .period_stb(period_stb), .running(running));

   always #5 clk = ~clk;

   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s got=%0d want=%0d t=%0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // Position in the period is a phase p; the counter value is derived from
   // it arithmetically (edge: p, centre: triangle of p over 2*TOP).
   int m_run = 0, m_mode_sh = 0, m_mode_act = 0, m_pre = 0;
   int m_top_sh = 0, m_top_act = 0;
   int m_duty_sh[NUM_CH], m_duty_act[NUM_CH];
   int m_pcnt = 0, m_p = 0;
   bit m_fresh = 1, m_bnd_d = 0;
   logic [NUM_CH-1:0] m_pwm = '0;
   logic m_stb = 1'b0;

   task automatic model_step();
      int n_run, n_mode, n_pre, n_top, c, a, d;
      int n_duty[NUM_CH];
      bit tick, bnd;
      if (rst) begin
         m_run = 0; m_mode_sh = 0; m_mode_act = 0; m_pre = 0;
         m_top_sh = 0; m_top_act = 0; m_pcnt = 0; m_p = 0;
         m_fresh = 1; m_bnd_d = 0; m_pwm = '0; m_stb = 1'b0;
         for (int i = 0; i < NUM_CH; i++) begin
            m_duty_sh[i] = 0; m_duty_act[i] = 0;
         end
         return;
      end
      n_run = m_run; n_mode = m_mode_sh; n_pre = m_pre; n_top = m_top_sh;
      n_duty = m_duty_sh;
      a = int'(cfg_addr); d = int'(cfg_wdata);
      if (cfg_we) begin
         if (a == 0) begin n_run = d & 1; n_mode = (d >> 1) & 1; end
         else if (a == 1) n_pre = d;
         else if (a == 2) n_top = d;
         else if (a - 3 < NUM_CH) n_duty[a-3] = d;
      end
      bnd = 0;
      if (m_run != 0) begin
         c = (m_mode_act == 0 || m_p <= m_top_act) ? m_p : 2 * m_top_act - m_p;
         for (int i = 0; i < NUM_CH; i++)
            m_pwm[i] = ch_en[i] & ((c < m_duty_act[i]) ^ ch_pol[i]);
         m_stb = m_bnd_d;
         tick = (m_pcnt == m_pre);
         if (tick) begin
            bnd = (m_mode_act == 0) ? (m_p == m_top_act)
                                    : (m_top_act == 0 || (m_p == 0 && !m_fresh));
            m_pcnt = 0;
            if (bnd) begin
               if (n_mode != m_mode_act) begin m_p = 0; m_fresh = 1; end
               else begin m_p = (n_mode == 0 || n_top == 0) ? 0 : 1; m_fresh = 0; end
            end else begin
               m_p = (m_mode_act == 0) ? m_p + 1 : (m_p + 1) % (2 * m_top_act);
               m_fresh = 0;
            end
         end else begin
            m_pcnt = (m_pcnt + 1) & MASK;
         end
      end else begin
         m_pwm = '0; m_stb = 1'b0; m_pcnt = 0; m_p = 0; m_fresh = 1;
      end
      if (m_run == 0 || bnd) begin
         m_mode_act = n_mode; m_top_act = n_top; m_duty_act = n_duty;
      end
      m_bnd_d = bnd; m_run = n_run; m_mode_sh = n_mode; m_pre = n_pre;
      m_top_sh = n_top; m_duty_sh = n_duty;
   endtask

   initial forever begin
      @(posedge clk);
      model_step();
   end

   // single compare process, every cycle, away from the active edge
   initial forever begin
      @(negedge clk);
      chk("pwm_out", int'(pwm_out), int'(m_pwm));
      chk("period_stb", int'(period_stb), int'(m_stb));
      chk("running", int'(running), m_run);
   end

   // ---------------- stimulus helpers ----------------
   task automatic to_pos();
      @(posedge clk); #1;
   endtask

   task automatic wr(input int a, input int d);
      cfg_we = 1'b1; cfg_addr = ADDR_W'(a); cfg_wdata = CNT_W'(d);
      to_pos();
      cfg_we = 1'b0;
   endtask

   task automatic wait_stb();
      int n = 0;
      do begin @(negedge clk); n++; end while (!period_stb && n < 2000);
      if (!period_stb) chk("stb_timeout", 0, 1);
   endtask

   task automatic sync(input int k);
      for (int j = 0; j < k; j++) wait_stb();
   endtask

   // counts pwm_out[0] highs and strobes over n samples, current sample first
   task automatic count(input int n, output int hi, output int st);
      hi = 0; st = 0;
      for (int k = 0; k < n; k++) begin
         if (k > 0) @(negedge clk);
         hi += int'(pwm_out[0]);
         st += int'(period_stb);
      end
   endtask

   // ---------------- main sequence ----------------
   initial begin
      int hi, st, hi2, co;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_pwm", int'(pwm_out), 0);
      chk("rst_run", int'(running), 0);
      chk("rst_stb", int'(period_stb), 0);
      to_pos();

      // edge mode: TOP=9, DUTY0=3
      ch_en = '1;
      wr(1, 0); wr(2, 9); wr(3, 3); wr(0, 1);
      sync(1);
      co = int'(pwm_out[0] & period_stb);
      count(20, hi, st);
      chk("edge_coincident", co, 1);
      chk("edge_hi", hi, 6);
      chk("edge_stb", st, 2);

      // prescale: PRESCALE=3, TOP=1, DUTY0=1
      to_pos();
      wr(1, 3); wr(2, 1); wr(3, 1);
      sync(3);
      count(16, hi, st);
      chk("pre_hi", hi, 8);
      chk("pre_stb", st, 2);

      // centre mode: TOP=4, DUTY0=2
      to_pos();
      wr(1, 0); wr(2, 4); wr(3, 2); wr(0, 3);
      sync(3);
      co = int'(pwm_out[0]);
      count(16, hi, st);
      chk("ctr_at_stb", co, 1);
      chk("ctr_hi", hi, 6);
      chk("ctr_stb", st, 2);

      // shadowed duty update mid-period
      to_pos();
      wr(0, 1); wr(2, 9); wr(3, 3);
      sync(3);
      fork
         count(10, hi, st);
         begin to_pos(); wr(3, 7); end
      join
      @(negedge clk);
      count(10, hi2, st);
      chk("shadow_old", hi, 3);
      chk("shadow_new", hi2, 7);

      // extremes and polarity
      to_pos(); wr(3, 0);   sync(2); count(10, hi, st); chk("duty0", hi, 0);
      to_pos(); wr(3, 10);  sync(2); count(10, hi, st); chk("duty_top1", hi, 10);
      to_pos(); wr(3, 255); sync(2); count(10, hi, st); chk("duty255", hi, 10);
      to_pos(); wr(3, 3); ch_pol[0] = 1'b1;
      sync(2); count(10, hi, st); chk("pol_inv", hi, 7);
      to_pos(); ch_pol[0] = 1'b0;

      // enable cleared mid-pulse
      wr(4, 5);
      sync(2);
      chk("en_before", int'(pwm_out[1]), 1);
      to_pos(); ch_en[1] = 1'b0;
      @(negedge clk); chk("en_mid", int'(pwm_out[1]), 1);
      @(negedge clk); chk("en_off", int'(pwm_out[1]), 0);
      to_pos(); ch_en[1] = 1'b1;

      // stop, then restart from cnt=0
      wr(0, 0);
      @(negedge clk); chk("stop_running", int'(running), 0);
      @(negedge clk);
      count(20, hi, st);
      chk("stop_hi", hi, 0);
      chk("stop_stb", st, 0);
      to_pos(); wr(0, 1);
      @(negedge clk);
      count(11, hi, st);
      chk("restart_hi", hi, 3);

      // reset during an active pulse
      sync(1);
      to_pos(); rst = 1'b1;
      to_pos(); rst = 1'b0;
      @(negedge clk);
      chk("mrst_pwm", int'(pwm_out), 0);
      chk("mrst_run", int'(running), 0);
      chk("mrst_stb", int'(period_stb), 0);
      to_pos(); wr(0, 1);
      @(negedge clk);
      count(20, hi, st);
      chk("mrst_nodduty", hi, 0);

      // randomized configuration traffic
      to_pos();
      for (int it = 0; it < 400; it++) begin
         int r, a, d;
         r = $urandom_range(0, 9);
         if (r <= 5) begin
            a = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 10);
            case (a)
               0:       d = ($urandom_range(0, 1) << 1) | (($urandom_range(0, 4) != 0) ? 1 : 0);
               1:       d = $urandom_range(0, 2);
               2:       d = $urandom_range(0, 12);
               default: d = $urandom_range(0, 15);
            endcase
            wr(a, d);
         end else if (r == 6) begin
            ch_en = NUM_CH'($urandom);
         end else if (r == 7) begin
            ch_pol = NUM_CH'($urandom);
         end else if (r == 8 && $urandom_range(0, 5) == 0) begin
            rst = 1'b1; to_pos(); rst = 1'b0;
         end
         repeat ($urandom_range(0, 6)) to_pos();
      end

      @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/pwm_multi_gen.md
Name: pwm_multi_gen

Overview:
Parametrised multi-channel PWM generator, successor to the single-output PWM behind the SPI register file in the tt_um_uwasic_onboarding top.
- One shared prescaled timebase drives NUM_CH compare channels.
- Supports edge-aligned and centre-aligned modes, per-channel enable and polarity, and glitch-free shadowed updates at period boundaries.
- Configured through a simple write port that the SPI peripheral drives.

Parameters:
NUM_CH, 8, number of PWM channels (1..16)
CNT_W, 8, width of counter, TOP, duty and prescale registers (4..16)
ADDR_W, 5, config address width; must satisfy 2^ADDR_W >= NUM_CH+3

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
cfg_we  in  1  config write strobe, one write per cycle
cfg_addr  in  ADDR_W  register address
cfg_wdata  in  CNT_W  write data
ch_en  in  NUM_CH  per-channel output enable (live, not shadowed)
ch_pol  in  NUM_CH  per-channel polarity, 1 = invert active level (live)
pwm_out  out  NUM_CH  registered PWM outputs
period_stb  out  1  one-clk pulse at each period boundary
running  out  1  mirrors CTRL.run

Behaviour:
- Register map:
  - 0 CTRL: bit0 run, bit1 mode (0 edge, 1 centre).
  - 1 PRESCALE.
  - 2 TOP.
  - 3+i DUTY[i] for i < NUM_CH.
  - Other addresses: write ignored.
  - Bits of CTRL above bit1 are ignored.
- Reset: all registers (shadow and active), prescaler, counter and dir(up) clear to 0. pwm_out=0, period_stb=0, running=0.
- run is applied immediately.
- mode, TOP and DUTY are shadow registers:
  - Copied to the active set on each period boundary.
  - Copied continuously while run=0, so values written while stopped are active on the first count.
- Prescaler:
  - pre_cnt counts 0..PRESCALE. tick=1 when pre_cnt==PRESCALE, then pre_cnt returns to 0.
  - Counter advances only on tick.
  - PRESCALE=0 gives a tick every clk.
- Edge mode:
  - cnt steps 0,1,..,TOP,0.
  - Boundary = tick while cnt==TOP.
  - Period = (TOP+1)*(PRESCALE+1) clk.
- Centre mode:
  - cnt steps up to TOP, then down to 0. Each endpoint is held for one tick only; dir flips on reaching TOP or 0.
  - Boundary = tick while cnt==0 and dir down (the turn-around).
  - Period = 2*TOP*(PRESCALE+1) clk.
  - TOP=0: cnt stays 0 and every tick is a boundary.
- Compare: act[i] = (cnt < duty_act[i]).
  - duty=0: never active.
  - duty > TOP: always active, in both modes.
- Output register: pwm_out[i] <= run & ch_en[i] & (act[i] ^ ch_pol[i]).
  - pwm_out lags the cnt value by exactly 1 clk.
  - Outputs are 0 when stopped or disabled, regardless of polarity.
- period_stb is registered and asserted the clk after the boundary tick, aligned with the first pwm_out of the new period.
- run 1->0: pre_cnt, cnt and dir reset at the next edge; pwm_out=0 the same edge. No period_stb is generated.
- run 0->1: counting starts from cnt=0 on the next edge.
- Config write in the same cycle as a boundary: the new value is included in that copy (write-through to active).
- Mode change while running: takes effect at the boundary. The counter restarts at 0 with dir up.
- Comparison and arithmetic are unsigned, CNT_W bits. The counter never exceeds active TOP because TOP only changes at a boundary.
- rst has priority over cfg_we and run.

Test Plan:
- Edge-mode duty: NUM_CH=8, CNT_W=8, PRESCALE=0, TOP=9, DUTY0=3, ch_en=1, run=1 -> pwm_out[0] high 3 clk, low 7 clk, repeating. period_stb every 10 clk, coincident with the rising pwm_out[0].
- Prescale: PRESCALE=3, TOP=1, DUTY0=1 -> pwm_out[0] high 4 clk, low 4 clk. period_stb every 8 clk.
- Centre mode: mode=1, TOP=4, DUTY0=2, PRESCALE=0 -> period 8 clk. pwm_out[0] high for 3 contiguous clk (cnt 1,0,1) centred on the boundary, low 5.
- Shadow and extremes:
  - Mid-period write DUTY0 3->7 (TOP=9): the current period keeps width 3 and the next period has width 7.
  - DUTY0=0 -> constant 0.
  - DUTY0=10 or 255 -> constant 1.
  - ch_pol[0]=1 -> inverted waveform.
- Enable and stop:
  - Clearing ch_en[1] mid-pulse forces pwm_out[1]=0 on the next clk.
  - run=0 -> all outputs 0 next clk and no period_stb.
  - run=1 again -> first period starts from cnt=0 with the full configured width.
- Reset mid-operation: assert rst for 1 clk during an active pulse -> pwm_out=0, running=0, period_stb=0 next clk. All config reads back as 0 in behaviour: no output after run=1 until DUTY is rewritten.
